// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: captures OP/A/B on an accepted start, runs single-cycle ops directly and SHIFT/MUL iteratively.
// Latency: done 1 cycle after start for simple ops, k+1 for SHIFT by k, WIDTH+1 for MUL.
// No backpressure: start is honoured only while idle, and is dropped otherwise; busy tells the requester to wait.
module alu_multicycle #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic [WIDTH-1:0] Out,
    output logic             Carry,
    output logic             Zero,
    output logic             Parity,
    output logic             Odd,
    output logic             busy,
    output logic             done
);

    // Iteration counter must hold WIDTH for the multiply.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_SHIFT = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;        // multiplicand, or the shifting operand
    logic [2*WIDTH-1:0]   prod_q, prod_d;  // {partial high, remaining multiplier / low bits}
    logic [CW-1:0]        cnt_q, cnt_d;    // iterations left in RUN
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 carry_q, carry_d;

    logic [WIDTH:0]       add_res;
    logic [WIDTH:0]       sub_res;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_step;
    logic [WIDTH-1:0]     a_shl;
    logic [SHW-1:0]       shamt;

    // Datapath helpers: one-shot arithmetic from the live inputs, one iteration step from the captured state.
    always_comb begin
        add_res   = {1'b0, InputA} + {1'b0, InputB};
        sub_res   = {1'b0, InputA} - {1'b0, InputB};
        shamt     = InputB[SHW-1:0];
        // Right-shifting shift-add: add A into the high half when the current multiplier bit is set.
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        prod_step = {mul_sum, prod_q[WIDTH-1:1]};
        a_shl     = {a_q[WIDTH-2:0], 1'b0};
    end

    // Next-state and result computation; Out/Carry only change on the transition into DONE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        carry_d = carry_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = OP;
                    a_d     = InputA;
                    prod_d  = {{WIDTH{1'b0}}, InputB};
                    state_d = DONE;
                    case (OP)
                        OP_ADD: begin
                            out_d   = add_res[WIDTH-1:0];
                            carry_d = add_res[WIDTH];
                        end
                        OP_XOR: begin
                            out_d   = InputA ^ InputB;
                            carry_d = 1'b0;
                        end
                        OP_AND: begin
                            out_d   = InputA & InputB;
                            carry_d = 1'b0;
                        end
                        OP_SUB: begin
                            out_d   = sub_res[WIDTH-1:0];
                            carry_d = sub_res[WIDTH];
                        end
                        OP_OR: begin
                            out_d   = InputA | InputB;
                            carry_d = 1'b0;
                        end
                        OP_SHIFT: begin
                            if (shamt == '0) begin
                                // Zero shift finishes at once with nothing shifted out.
                                out_d   = InputA;
                                carry_d = 1'b0;
                            end else begin
                                cnt_d   = CW'(shamt);
                                state_d = RUN;
                            end
                        end
                        OP_MUL: begin
                            cnt_d   = CW'(WIDTH);
                            state_d = RUN;
                        end
                        default: begin
                            out_d   = '0;
                            carry_d = 1'b0;
                        end
                    endcase
                end
            end

            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_SHIFT) begin
                    a_d = a_shl;
                    if (cnt_q == CW'(1)) begin
                        out_d   = a_shl;
                        carry_d = a_q[WIDTH-1];
                        state_d = DONE;
                    end
                end else begin
                    prod_d = prod_step;
                    if (cnt_q == CW'(1)) begin
                        out_d   = prod_step[WIDTH-1:0];
                        carry_d = |prod_step[2*WIDTH-1:WIDTH];
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    // Status and flags decode straight from registered state, so they are glitch-free.
    always_comb begin
        Out    = out_q;
        Carry  = carry_q;
        Zero   = (out_q == '0);
        Parity = ^out_q;
        Odd    = out_q[0];
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=8.
// Latency: checks done position per op class and flag values against hand-computed results.
// Backpressure: also pulses start while busy/done and confirms it is ignored.
module tb_alu_multicycle;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] OP;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic [7:0] Out;
    logic       Carry;
    logic       Zero;
    logic       Parity;
    logic       Odd;
    logic       busy;
    logic       done;

    int errors;
    int checks;
    logic [7:0] prev_out;

    alu_multicycle #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .OP     (OP),
        .InputA (InputA),
        .InputB (InputB),
        .Out    (Out),
        .Carry  (Carry),
        .Zero   (Zero),
        .Parity (Parity),
        .Odd    (Odd),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the operands afterwards, and check latency, busy, hold and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [7:0] exp_out, input logic exp_carry);
        int cyc;
        int busy_low;
        int out_moved;
        start  = 1'b1;
        OP     = op;
        InputA = a;
        InputB = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        OP     = 3'($urandom);
        InputA = 8'($urandom);
        InputB = 8'($urandom);
        cyc       = 1;
        busy_low  = 0;
        out_moved = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_low++;
            if (Out !== prev_out) out_moved++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " busy low before done"}, busy_low, 0);
        chk({tag, " out held before done"}, out_moved, 0);
        chk({tag, " busy in done cycle"}, {31'b0, busy}, 1);
        chk({tag, " Out"}, {24'b0, Out}, {24'b0, exp_out});
        chk({tag, " Carry"}, {31'b0, Carry}, {31'b0, exp_carry});
        chk({tag, " Zero"}, {31'b0, Zero}, {31'b0, (exp_out == 8'h00)});
        chk({tag, " Parity"}, {31'b0, Parity}, {31'b0, ^exp_out});
        chk({tag, " Odd"}, {31'b0, Odd}, {31'b0, exp_out[0]});
        // A start presented during the done cycle must be dropped.
        start  = 1'b1;
        OP     = 3'b101;
        InputA = 8'h3C;
        InputB = 8'hC3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " done after pulse"}, {31'b0, done}, 0);
        chk({tag, " busy after done"}, {31'b0, busy}, 0);
        chk({tag, " Out hold after done"}, {24'b0, Out}, {24'b0, exp_out});
        prev_out = exp_out;
    endtask

    initial begin
        int saw_done;
        errors   = 0;
        checks   = 0;
        prev_out = 8'h00;
        reset    = 1'b1;
        start    = 1'b0;
        OP       = 3'b000;
        InputA   = 8'h00;
        InputB   = 8'h00;

        // Reset state, observed before any clock edge.
        #3;
        chk("rst busy",   {31'b0, busy},   0);
        chk("rst done",   {31'b0, done},   0);
        chk("rst Out",    {24'b0, Out},    0);
        chk("rst Carry",  {31'b0, Carry},  0);
        chk("rst Zero",   {31'b0, Zero},   1);
        chk("rst Parity", {31'b0, Parity}, 0);
        chk("rst Odd",    {31'b0, Odd},    0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("add",    3'b000, 8'hF0, 8'h20, 1, 8'h10, 1'b1);
        run_op("sub",    3'b100, 8'h05, 8'h07, 1, 8'hFE, 1'b1);
        run_op("shl3",   3'b010, 8'h81, 8'h03, 4, 8'h08, 1'b0);
        run_op("shl1",   3'b010, 8'h81, 8'h01, 2, 8'h02, 1'b1);
        run_op("shl0",   3'b010, 8'h5A, 8'h08, 1, 8'h5A, 1'b0);
        run_op("mul",    3'b110, 8'h13, 8'h0D, 9, 8'hF7, 1'b0);
        run_op("mulovf", 3'b110, 8'h10, 8'h10, 9, 8'h00, 1'b1);
        run_op("xor",    3'b001, 8'hA5, 8'h0F, 1, 8'hAA, 1'b0);
        run_op("and",    3'b011, 8'hA5, 8'h0F, 1, 8'h05, 1'b0);
        run_op("or",     3'b101, 8'hA0, 8'h07, 1, 8'hA7, 1'b0);
        run_op("nop",    3'b111, 8'hFF, 8'hFF, 1, 8'h00, 1'b0);
        run_op("addwrap",3'b000, 8'hFF, 8'h01, 1, 8'h00, 1'b1);
        run_op("subeq",  3'b100, 8'h07, 8'h07, 1, 8'h00, 1'b0);
        run_op("or2",    3'b101, 8'h31, 8'h00, 1, 8'h31, 1'b0);

        // Abort: MUL started, ADD start during RUN is ignored, async reset mid-operation.
        start  = 1'b1;
        OP     = 3'b110;
        InputA = 8'h13;
        InputB = 8'h0D;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start  = 1'b1;
        OP     = 3'b000;
        InputA = 8'h01;
        InputB = 8'h02;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort busy in run",  {31'b0, busy}, 1);
        chk("abort out unchanged", {24'b0, Out}, {24'b0, prev_out});
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort busy",  {31'b0, busy},  0);
        chk("abort done",  {31'b0, done},  0);
        chk("abort Out",   {24'b0, Out},   0);
        chk("abort Zero",  {31'b0, Zero},  1);
        chk("abort Carry", {31'b0, Carry}, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        prev_out = 8'h00;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done++;
            @(posedge clk);
            #1;
        end
        chk("abort no done", saw_done, 0);

        run_op("after rst", 3'b000, 8'h01, 8'h02, 1, 8'h03, 1'b0);
        run_op("mul after", 3'b110, 8'hFF, 8'hFF, 9, 8'h01, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHW = clog2(WIDTH), shift-amount width.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled only while busy is low.
REQ-005 Port: OP  input  3  operation code, captured with start.
REQ-006 Port: InputA  input  WIDTH  operand A, captured with start.
REQ-007 Port: InputB  input  WIDTH  operand B, captured with start.
REQ-008 Port: Out  output  WIDTH  registered result.
REQ-009 Port: Carry  output  1  registered carry/borrow/overflow flag.
REQ-010 Port: Zero, Parity, Odd  output  1 each  flags derived combinationally from Out.
REQ-011 Port: busy  output  1  high whenever the FSM is not IDLE.
REQ-012 Port: done  output  1  single-cycle pulse; Out/Carry valid and updated in that cycle.

Function
REQ-013 OP encoding SHALL be: 000 ADD, 001 XOR, 010 SHIFT, 011 AND, 100 SUB, 101 OR, 110 MUL, 111 NOP (result 0).
REQ-014 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start with iterative op; IDLE->DONE on start with single-cycle op; RUN->DONE after last iteration; DONE->IDLE unconditionally.
REQ-015 start SHALL be accepted only in IDLE; start in RUN or DONE SHALL be ignored, with no operand capture.
REQ-016 ADD, XOR, AND, SUB, OR, NOP, and SHIFT by 0 SHALL assert done exactly 1 cycle after the start edge.
REQ-017 SHIFT SHALL shift captured A left one bit per RUN cycle, k = InputB[SHW-1:0] times, zero fill; done k+1 cycles after the start edge.
REQ-018 MUL SHALL be iterative shift-add over WIDTH RUN cycles, unsigned; Out = low WIDTH bits of A*B; done WIDTH+1 cycles after the start edge.
REQ-019 Carry: ADD = carry out of bit WIDTH-1; SUB = borrow (1 iff A<B unsigned); SHIFT = last bit shifted out (0 if k=0); MUL = 1 iff upper WIDTH product bits nonzero; all other ops 0.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-021 Out and Carry SHALL update only in the cycle done rises and hold until the next done.
REQ-022 Zero = (Out == 0); Parity = XOR reduction of Out; Odd = Out[0].
REQ-023 Operand inputs changing after the start edge SHALL NOT affect the result.
REQ-024 done SHALL be high for exactly one cycle per accepted start; busy SHALL be high from the cycle after the start edge through the done cycle inclusive.

Reset
REQ-025 reset SHALL act immediately, without clk: state IDLE, Out 0, Carry 0, busy 0, done 0; hence Zero 1, Parity 0, Odd 0.
REQ-026 reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted request.
REQ-027 After reset deasserts, the first start SHALL be accepted on the next clk edge.

Verification (WIDTH=8)
REQ-028 ADD A=0xF0 B=0x20 -> done 1 cycle later; Out 0x10, Carry 1, Zero 0, Parity 1, Odd 0.
REQ-029 SUB A=0x05 B=0x07 -> done 1 cycle later; Out 0xFE, Carry 1, Parity 1, Odd 0.
REQ-030 SHIFT A=0x81 B=0x03 -> busy 4 cycles, done at cycle 4; Out 0x08, Carry 0; with B=0x01, Out 0x02, Carry 1 at cycle 2.
REQ-031 MUL 0x13*0x0D -> done at cycle 9, Out 0xF7, Carry 0; MUL 0x10*0x10 -> Out 0x00, Zero 1, Carry 1.
REQ-032 MUL started, start re-pulsed with ADD at cycle 3, reset at cycle 5 -> second start ignored; busy 0, Out 0, Zero 1, no done; a new start after reset completes normally.
REQ-033 NOP (OP=111) with A=0xFF B=0xFF -> done 1 cycle later; Out 0x00, Zero 1, Carry 0.
